hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It watches the ID/EX and EX/MEM stage contents and generates the stall and flush controls that the IF/ID and ID/EX registers and the PC consume, including the `flush_IDEX` bubble input of the ID/EX register. It covers:
- load-use stalls;
- multi-cycle stalls for register jumps whose target is read in ID;
- control-redirect flushes.

A small bubble-count FSM makes every stall length explicit. Free-running event counters support performance debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall and flush event counters.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rs_ID`  in  5: rs field of the instruction in ID.
- `rt_ID`  in  5: rt field of the instruction in ID.
- `UseRs_ID`  in  1: the ID instruction reads rs.
- `UseRt_ID`  in  1: the ID instruction reads rt.
- `JumpReg_ID`  in  1: the ID instruction is JR/JALR; its target rs is needed in ID.
- `Jump_ID`  in  1: the ID instruction is J/JAL/JR/JALR (redirect resolved in ID).
- `RegWrite_EX`  in  1: the EX instruction writes a register.
- `MemRead_EX`  in  1: the EX instruction is a load.
- `WriteReg_EX`  in  5: destination register of the EX instruction, after the RegDst select.
- `MemRead_MEM`  in  1: the MEM instruction is a load.
- `WriteReg_MEM`  in  5: destination register of the MEM instruction.
- `BranchTaken_EX`  in  1: a conditional branch resolved taken in EX.
- `stall_PC`  out  1: hold the PC.
- `stall_IFID`  out  1: hold the IF/ID register.
- `flush_IFID`  out  1: zero the IF/ID register.
- `flush_IDEX`  out  1: insert a bubble into ID/EX.
- `stall_cnt`  out  CNT_W: count of stall cycles.
- `flush_cnt`  out  CNT_W: count of redirect events.

## Operation
Hazard terms. A match against register 0 never counts as a hazard.
- `lu`: `MemRead_EX && WriteReg_EX!=0 && ((UseRs_ID && WriteReg_EX==rs_ID) || (UseRt_ID && WriteReg_EX==rt_ID))`. Needs 1 bubble.
- `jr_ex`: `JumpReg_ID && RegWrite_EX && WriteReg_EX!=0 && WriteReg_EX==rs_ID`. Needs 2 bubbles if `MemRead_EX`, otherwise 1.
- `jr_mem`: `JumpReg_ID && MemRead_MEM && WriteReg_MEM!=0 && WriteReg_MEM==rs_ID`. Needs 1 bubble.
- Required bubbles `n` = the maximum over the active terms; `n` is 0 if no term is active.

FSM states (shared enum):
- `RUN`: detection is active.
  - If `n>0`: stall this cycle and load `bub_q <= n-1`.
  - Next state is `HOLD` if `n==2`, otherwise `RUN`.
- `HOLD`: detection is ignored.
  - Stall this cycle, `bub_q` decrements.
  - Return to `RUN` when `bub_q` reaches 0.

Stall outputs, asserted in the detecting cycle and in every `HOLD` cycle:
- `stall_PC = stall_IFID = flush_IDEX = 1`, `flush_IFID = 0`.

Priority, highest first:
1. `BranchTaken_EX`:
   - `flush_IFID = flush_IDEX = 1`, `stall_PC = stall_IFID = 0`.
   - The FSM is forced to `RUN` and `bub_q` to 0; any pending stall is abandoned.
   - `flush_cnt` increments.
2. Stall, as above. A `Jump_ID` in the same cycle is deferred until the jump leaves the stall.
3. `Jump_ID` with no stall: `flush_IFID = 1`, `flush_cnt` increments.

Counters:
- `stall_cnt` increments on every cycle with `stall_PC = 1`.
- Both counters wrap modulo 2^CNT_W.

## Timing
- All four control outputs are combinational from the current inputs and the FSM state. They take effect at the next rising edge in the consuming registers.
- The FSM, `bub_q` and the counters are registered. Latency from input to output is 0 cycles.
- While `reset_n` = 0: state `RUN`, `bub_q = 0`, all control outputs 0, `stall_cnt = flush_cnt = 0`.
- Reset is asynchronous on assertion and is released on the next edge after deassertion.
- Reset asserted during `HOLD` abandons the stall immediately.
- A load followed by JR on the same register gives exactly 2 stall cycles, then JR's redirect `flush_IFID` on the 3rd cycle.
- Inputs are sampled only in `RUN`. Hazards that change during `HOLD` have no effect.

## Structure
- Shared package `mips_pkg`:
  - `hz_state_t` enum (`RUN`, `HOLD`).
  - `REG_ZERO = 5'd0`.
  - The bubble-count width constant (2 bits).
- Single module. Both counters share one sub-module, `event_counter` (parameter `CNT_W`; ports `clk`, `reset_n`, `inc`, `count`), instantiated twice.

## Test plan
- **Plain load-use:** `lw $8` in EX (`MemRead_EX=1`, `WriteReg_EX=8`); `add` in ID with `rs_ID=8`, `UseRs_ID=1`. Expect one cycle of `stall_PC = stall_IFID = flush_IDEX = 1`, then all 0; `stall_cnt` = 1.
- **Load then JR:** `lw $31` in EX, `JumpReg_ID=1`, `Jump_ID=1`, `rs_ID=31`. Expect 2 stall cycles (second in `HOLD`), then `flush_IFID=1` with `flush_IDEX=0`; `stall_cnt` = 2, `flush_cnt` = 1.
- **ALU then JR:** `RegWrite_EX=1`, `MemRead_EX=0`, `WriteReg_EX=5`, JR with `rs_ID=5`. Expect exactly 1 stall cycle.
- **Register 0:** `lw $0` in EX, ID uses `rs=0`. Expect no stall.
- **Branch priority:** `BranchTaken_EX=1` in the same cycle as an `lu` match. Expect `flush_IFID = flush_IDEX = 1`, `stall_PC=0`, state `RUN`, `flush_cnt` +1.
- **Reset mid-stall:** drop `reset_n` during `HOLD`. Expect all outputs 0 at once and both counters 0. After release, an idle pipeline produces no stall.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         BUB_W    = 2;

    function automatic logic [BUB_W-1:0] bub_max(
        input logic [BUB_W-1:0] a,
        input logic [BUB_W-1:0] b
    );
        bub_max = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter for performance debug.
module event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count qualifying cycles, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and JR stalls with an explicit
// bubble-count FSM, plus redirect flushes and event counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             UseRs_ID,
    input  logic             UseRt_ID,
    input  logic             JumpReg_ID,
    input  logic             Jump_ID,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic [4:0]       WriteReg_EX,
    input  logic             MemRead_MEM,
    input  logic [4:0]       WriteReg_MEM,
    input  logic             BranchTaken_EX,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t        state_r, state_nxt_s;
    logic [BUB_W-1:0] bub_r, bub_nxt_s;
    logic             lu_s, jr_ex_s, jr_mem_s;
    logic [BUB_W-1:0] lu_bub_s, jr_ex_bub_s, jr_mem_bub_s, need_s;
    logic             stall_s, flush_ifid_s, flush_idex_s, flush_inc_s;

    assign lu_s = MemRead_EX && (WriteReg_EX != REG_ZERO) &&
                  ((UseRs_ID && (WriteReg_EX == rs_ID)) ||
                   (UseRt_ID && (WriteReg_EX == rt_ID)));
    assign jr_ex_s = JumpReg_ID && RegWrite_EX && (WriteReg_EX != REG_ZERO) &&
                     (WriteReg_EX == rs_ID);
    assign jr_mem_s = JumpReg_ID && MemRead_MEM && (WriteReg_MEM != REG_ZERO) &&
                      (WriteReg_MEM == rs_ID);

    // A load feeding a JR target needs an extra bubble to reach MEM/WB forwarding.
    assign lu_bub_s     = lu_s ? BUB_W'(1) : BUB_W'(0);
    assign jr_ex_bub_s  = jr_ex_s ? (MemRead_EX ? BUB_W'(2) : BUB_W'(1)) : BUB_W'(0);
    assign jr_mem_bub_s = jr_mem_s ? BUB_W'(1) : BUB_W'(0);
    assign need_s       = bub_max(bub_max(lu_bub_s, jr_ex_bub_s), jr_mem_bub_s);

    // Next-state and control decode; a taken branch overrides any stall.
    always_comb begin
        state_nxt_s  = state_r;
        bub_nxt_s    = bub_r;
        stall_s      = 1'b0;
        flush_ifid_s = 1'b0;
        flush_idex_s = 1'b0;
        flush_inc_s  = 1'b0;
        if (!reset_n) begin
            state_nxt_s = RUN;
            bub_nxt_s   = BUB_W'(0);
        end else if (BranchTaken_EX) begin
            flush_ifid_s = 1'b1;
            flush_idex_s = 1'b1;
            flush_inc_s  = 1'b1;
            state_nxt_s  = RUN;
            bub_nxt_s    = BUB_W'(0);
        end else begin
            case (state_r)
                RUN: begin
                    if (need_s != BUB_W'(0)) begin
                        stall_s     = 1'b1;
                        bub_nxt_s   = need_s - BUB_W'(1);
                        state_nxt_s = (need_s == BUB_W'(2)) ? HOLD : RUN;
                    end else if (Jump_ID) begin
                        flush_ifid_s = 1'b1;
                        flush_inc_s  = 1'b1;
                    end else begin
                        bub_nxt_s = BUB_W'(0);
                    end
                end
                HOLD: begin
                    stall_s   = 1'b1;
                    bub_nxt_s = bub_r - BUB_W'(1);
                    if (bub_r <= BUB_W'(1)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    bub_nxt_s   = BUB_W'(0);
                end
            endcase
        end
    end

    // FSM and bubble-count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RUN;
            bub_r   <= BUB_W'(0);
        end else begin
            state_r <= state_nxt_s;
            bub_r   <= bub_nxt_s;
        end
    end

    assign stall_PC   = stall_s;
    assign stall_IFID = stall_s;
    assign flush_IFID = flush_ifid_s;
    assign flush_IDEX = stall_s | flush_idex_s;

    event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_s),
        .count   (stall_cnt)
    );

    event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_inc_s),
        .count   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_ID, rt_ID, WriteReg_EX, WriteReg_MEM;
    logic        UseRs_ID, UseRt_ID, JumpReg_ID, Jump_ID;
    logic        RegWrite_EX, MemRead_EX, MemRead_MEM, BranchTaken_EX;
    logic        stall_PC, stall_IFID, flush_IFID, flush_IDEX;
    logic [31:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rs_ID          (rs_ID),
        .rt_ID          (rt_ID),
        .UseRs_ID       (UseRs_ID),
        .UseRt_ID       (UseRt_ID),
        .JumpReg_ID     (JumpReg_ID),
        .Jump_ID        (Jump_ID),
        .RegWrite_EX    (RegWrite_EX),
        .MemRead_EX     (MemRead_EX),
        .WriteReg_EX    (WriteReg_EX),
        .MemRead_MEM    (MemRead_MEM),
        .WriteReg_MEM   (WriteReg_MEM),
        .BranchTaken_EX (BranchTaken_EX),
        .stall_PC       (stall_PC),
        .stall_IFID     (stall_IFID),
        .flush_IFID     (flush_IFID),
        .flush_IDEX     (flush_IDEX),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic spc, input logic fif, input logic fid);
        chk({tag, ".stall_PC"},   {31'd0, stall_PC},   {31'd0, spc});
        chk({tag, ".stall_IFID"}, {31'd0, stall_IFID}, {31'd0, spc});
        chk({tag, ".flush_IFID"}, {31'd0, flush_IFID}, {31'd0, fif});
        chk({tag, ".flush_IDEX"}, {31'd0, flush_IDEX}, {31'd0, fid});
    endtask

    task automatic chk_state(input string tag, input hz_state_t exp);
        chk({tag, ".state"}, {31'd0, dut.state_r}, {31'd0, exp});
    endtask

    task automatic idle();
        rs_ID = 5'd0; rt_ID = 5'd0; UseRs_ID = 1'b0; UseRt_ID = 1'b0;
        JumpReg_ID = 1'b0; Jump_ID = 1'b0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0;
        WriteReg_EX = 5'd0; MemRead_MEM = 1'b0; WriteReg_MEM = 5'd0; BranchTaken_EX = 1'b0;
    endtask

    // lw $31 in EX with JR $31 in ID
    task automatic load_jr();
        idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WriteReg_EX = 5'd31;
        JumpReg_ID = 1'b1; Jump_ID = 1'b1; rs_ID = 5'd31; UseRs_ID = 1'b1;
    endtask

    // second cycle of load_jr: load in MEM, bubble in EX, JR still in ID
    task automatic load_jr_b();
        idle();
        MemRead_MEM = 1'b1; WriteReg_MEM = 5'd31;
        JumpReg_ID = 1'b1; Jump_ID = 1'b1; rs_ID = 5'd31; UseRs_ID = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        MemRead_EX = 1'b1; WriteReg_EX = 5'd8; rs_ID = 5'd8; UseRs_ID = 1'b1; Jump_ID = 1'b1;
        #2;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.flush_cnt", flush_cnt, 32'd0);
        chk_state("reset", RUN);

        @(negedge clk); idle(); reset_n = 1'b1;

        // plain load-use on rs
        @(negedge clk); idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WriteReg_EX = 5'd8; rs_ID = 5'd8; UseRs_ID = 1'b1;
        #2 chk_ctl("lu_rs", 1'b1, 1'b0, 1'b1);
        @(negedge clk); idle();
        MemRead_MEM = 1'b1; WriteReg_MEM = 5'd8; rs_ID = 5'd8; UseRs_ID = 1'b1;
        #2 chk_ctl("lu_rs_after", 1'b0, 1'b0, 1'b0);
        chk("lu_rs.stall_cnt", stall_cnt, 32'd1);

        // load-use on rt, then rt match without UseRt
        @(negedge clk); idle();
        MemRead_EX = 1'b1; WriteReg_EX = 5'd9; rt_ID = 5'd9; UseRt_ID = 1'b1; rs_ID = 5'd3; UseRs_ID = 1'b1;
        #2 chk_ctl("lu_rt", 1'b1, 1'b0, 1'b1);
        @(negedge clk); UseRt_ID = 1'b0;
        #2 chk_ctl("lu_rt_unused", 1'b0, 1'b0, 1'b0);
        chk("lu_rt.stall_cnt", stall_cnt, 32'd2);

        // register 0 never hazards
        @(negedge clk); idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WriteReg_EX = 5'd0; rs_ID = 5'd0; UseRs_ID = 1'b1;
        rt_ID = 5'd0; UseRt_ID = 1'b1; JumpReg_ID = 1'b1;
        #2 chk_ctl("reg0", 1'b0, 1'b0, 1'b0);

        // load then JR: two stalls, then redirect
        @(negedge clk); load_jr();
        #2 chk_ctl("ldjr_c1", 1'b1, 1'b0, 1'b1);
        @(negedge clk); load_jr_b();
        #2 chk_ctl("ldjr_c2", 1'b1, 1'b0, 1'b1);
        chk_state("ldjr_c2", HOLD);
        chk("ldjr_c2.stall_cnt", stall_cnt, 32'd3);
        @(negedge clk); idle(); JumpReg_ID = 1'b1; Jump_ID = 1'b1; rs_ID = 5'd31; UseRs_ID = 1'b1;
        #2 chk_ctl("ldjr_c3", 1'b0, 1'b1, 1'b0);
        chk_state("ldjr_c3", RUN);
        chk("ldjr_c3.stall_cnt", stall_cnt, 32'd4);
        chk("ldjr_c3.flush_cnt", flush_cnt, 32'd0);
        @(negedge clk); idle();
        #2 chk_ctl("ldjr_idle", 1'b0, 1'b0, 1'b0);
        chk("ldjr.flush_cnt", flush_cnt, 32'd1);

        // load in MEM feeding JR: one stall
        @(negedge clk); idle();
        MemRead_MEM = 1'b1; WriteReg_MEM = 5'd12; JumpReg_ID = 1'b1; Jump_ID = 1'b1; rs_ID = 5'd12; UseRs_ID = 1'b1;
        #2 chk_ctl("jrmem", 1'b1, 1'b0, 1'b1);
        @(negedge clk); MemRead_MEM = 1'b0;
        #2 chk_ctl("jrmem_after", 1'b0, 1'b1, 1'b0);
        chk("jrmem.stall_cnt", stall_cnt, 32'd5);

        // ALU then JR: exactly one stall
        @(negedge clk); idle();
        RegWrite_EX = 1'b1; WriteReg_EX = 5'd5; JumpReg_ID = 1'b1; Jump_ID = 1'b1; rs_ID = 5'd5; UseRs_ID = 1'b1;
        #2 chk_ctl("alujr", 1'b1, 1'b0, 1'b1);
        @(negedge clk); RegWrite_EX = 1'b0; WriteReg_EX = 5'd0;
        #2 chk_ctl("alujr_after", 1'b0, 1'b1, 1'b0);
        chk_state("alujr_after", RUN);
        chk("alujr.stall_cnt", stall_cnt, 32'd6);
        chk("alujr.flush_cnt", flush_cnt, 32'd2);

        // taken branch beats a load-use match
        @(negedge clk); idle();
        MemRead_EX = 1'b1; WriteReg_EX = 5'd8; rs_ID = 5'd8; UseRs_ID = 1'b1; BranchTaken_EX = 1'b1;
        #2 chk_ctl("br_lu", 1'b0, 1'b1, 1'b1);
        chk("br_lu.flush_cnt", flush_cnt, 32'd3);
        @(negedge clk); idle();
        #2 chk_ctl("br_lu_after", 1'b0, 1'b0, 1'b0);
        chk_state("br_lu_after", RUN);
        chk("br_lu.flush_cnt_inc", flush_cnt, 32'd4);
        chk("br_lu.stall_cnt", stall_cnt, 32'd6);

        // taken branch abandons a pending HOLD
        @(negedge clk); load_jr();
        #2 chk_ctl("brhold_c1", 1'b1, 1'b0, 1'b1);
        @(negedge clk); load_jr_b(); BranchTaken_EX = 1'b1;
        #2 chk_ctl("brhold_c2", 1'b0, 1'b1, 1'b1);
        @(negedge clk); idle();
        #2 chk_ctl("brhold_after", 1'b0, 1'b0, 1'b0);
        chk_state("brhold_after", RUN);
        chk("brhold.flush_cnt", flush_cnt, 32'd5);
        chk("brhold.stall_cnt", stall_cnt, 32'd7);

        // reset during HOLD
        @(negedge clk); load_jr();
        #2 chk_ctl("rsthold_c1", 1'b1, 1'b0, 1'b1);
        @(negedge clk); load_jr_b();
        #1 chk_state("rsthold_pre", HOLD);
        chk("rsthold_pre.stall_cnt", stall_cnt, 32'd8);
        reset_n = 1'b0;
        #1 chk_ctl("rsthold", 1'b0, 1'b0, 1'b0);
        chk_state("rsthold", RUN);
        chk("rsthold.stall_cnt", stall_cnt, 32'd0);
        chk("rsthold.flush_cnt", flush_cnt, 32'd0);
        @(negedge clk); idle(); reset_n = 1'b1;
        #2 chk_ctl("post_rst1", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 chk_ctl("post_rst2", 1'b0, 1'b0, 1'b0);
        chk("post_rst.stall_cnt", stall_cnt, 32'd0);
        chk("post_rst.flush_cnt", flush_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
